edge_extract: RTL
=================

// Module: edge_extract
// PURPOSE
//  Consumes the raster pixel stream from the image source: Pixel, plus Line and Frame markers, one pixel per Clk.
//  Computes a cheap gradient magnitude per pixel and keeps edge pixels only.
//  Queues edge coordinates in a small FIFO behind a valid/ready port that feeds the Hough voting stage.
//  Writes an end-of-frame entry so the voter knows when to close the accumulator.
// PARAMETERS
//  COLS        10   pixels per row
//  ROWS        10   rows per frame
//  CW          8    width of Edge_X / Edge_Y and internal col/row counters
//  THRESH      60   edge threshold on 9-bit magnitude; hit when mag >= THRESH
//  FIFO_DEPTH  16   output FIFO entries, power of 2, >= 2
// PORTS
//  Clk         in   1    single clock, all logic rising-edge
//  nReset      in   1    reset, asynchronous, active-high (asserted = 1)
//  Pixel       in   8    pixel value, valid every cycle
//  Frame       in   1    high with pixel (0,0) of a frame; Line also high then
//  Line        in   1    high with column-0 pixel of every row
//  Edge_Ready  in   1    consumer accepts the head entry this cycle
//  Edge_Valid  out  1    FIFO non-empty; head entry presented
//  Edge_X      out  CW   head entry column
//  Edge_Y      out  CW   head entry row
//  Edge_Hit    out  1    head entry is an edge pixel
//  Edge_Eof    out  1    head entry is the last pixel of its frame
//  Overflow    out  1    sticky: an entry was dropped because the FIFO was full
//  Sync_Err    out  1    sticky: Frame/Line arrived at an unexpected position
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state WAIT_FRAME, col/row counters 0. Line buffer contents are not reset.
//  Async assert mid-frame discards the FIFO and pipeline.
//  FSM WAIT_FRAME: pixels ignored until Frame=1. That pixel is (0,0); go to RUN.
//  FSM RUN: col increments each cycle. At COLS-1, col wraps to 0 and row increments. At (COLS-1,ROWS-1), both wrap to 0.
//  - Frame=1 when expected position != (0,0): set Sync_Err, force position (0,0), stay RUN.
//  - Line=1 (Frame=0) when col != 0: set Sync_Err, force col=0, row=row+1 (wrap at ROWS).
//  - Line=0 when col==0 is expected: no error; counters rule.
//  Line buffer: COLS x 8 regs. At position (x,y), read up=buf[x] and write buf[x]=Pixel in the same cycle.
//   Left pixel is the previous cycle's Pixel.
//  Stage 1 (sampling edge T): register Pixel, left, up, x, y.
//  Stage 2 (edge T+1): gx=|P-left|, gy=|P-up|, both 8b unsigned. mag=gx+gy, 9b, no saturation.
//   hit = (x>=1) && (y>=1) && (mag>=THRESH). Row 0 and column 0 never hit.
//   eof = (x==COLS-1) && (y==ROWS-1).
//   Entry {x,y,hit,eof} is written when hit|eof.
//  Latency: entry visible on Edge_Valid/outputs after edge T+2 when the FIFO was empty; FIFO is show-ahead.
//  Handshake: pop on Edge_Valid & Edge_Ready. Edge_Ready ignored when empty.
//   Outputs hold while Edge_Valid=1 & Edge_Ready=0.
//  Full: write accepted if not full, or if full with a pop in the same cycle. Otherwise drop it and set Overflow.
//   This includes eof entries.
//  Empty with write: entry appears next cycle; no same-cycle bypass.
//  Overflow and Sync_Err clear only on reset. Stream processing is never stalled by the FIFO.
// TESTING
//  Flat frame, all 100, Ready=1: exactly one entry (9,9,Hit=0,Eof=1); Overflow=0, Sync_Err=0.
//  Vertical step, cols0-4=50 / cols5-9=150: entries (5,1)..(5,9) Hit=1 in order, then (9,9,Hit=0,Eof=1); 10 total.
//  Horizontal step, rows0-4=50 / rows5-9=150: entries (1,5)..(9,5) Hit=1, then (9,9,0,1); (0,5) absent.
//  Threshold edge, left=100, P=160 (mag=60), up equal: hit. P=159 (mag=59): no entry.
//  FIFO_DEPTH=4, vertical step, Ready=0 all frame: first 4 entries (5,1)..(5,4) kept, Overflow=1.
//   Raise Ready: exactly those 4 drain, one per cycle.
//  Extra Line at col 3 of row 2: Sync_Err=1, next pixel counted (1,3).
//   Reset mid-frame: all outputs 0, pixels ignored until next Frame.

Source files
------------

// File: rtl/edge_extract.sv
// edge_extract: raster pixel stream -> gradient edge detector -> show-ahead
// coordinate FIFO for the Hough voting stage. One pixel per clock, never
// stalls; entries are dropped (and Overflow latched) when the FIFO is full.
module edge_extract #(
  parameter int COLS       = 10,
  parameter int ROWS       = 10,
  parameter int CW         = 8,
  parameter int THRESH     = 60,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic [7:0]    Pixel,
  input  logic          Frame,
  input  logic          Line,
  input  logic          Edge_Ready,
  output logic          Edge_Valid,
  output logic [CW-1:0] Edge_X,
  output logic [CW-1:0] Edge_Y,
  output logic          Edge_Hit,
  output logic          Edge_Eof,
  output logic          Overflow,
  output logic          Sync_Err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int EW = 2 * CW + 2;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  typedef enum logic {WAIT_FRAME, RUN} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic          r_sync_err;

  logic          w_pix_valid;
  logic          w_sync_hit;
  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic [CW-1:0] w_row_inc;
  logic [CW-1:0] w_x_next;
  logic [CW-1:0] w_y_next;
  logic [BW-1:0] w_buf_idx;

  // Resolve the position of the incoming pixel from counters and markers
  always_comb begin
    w_pix_valid = 1'b0;
    w_sync_hit  = 1'b0;
    w_x         = r_col;
    w_y         = r_row;
    w_row_inc   = (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
    case (r_state)
      WAIT_FRAME: begin
        if (Frame) begin
          w_pix_valid = 1'b1;
          w_x         = '0;
          w_y         = '0;
        end
      end
      RUN: begin
        w_pix_valid = 1'b1;
        if (Frame) begin
          // A frame marker always re-anchors to the origin.
          w_sync_hit = (r_col != '0) || (r_row != '0);
          w_x        = '0;
          w_y        = '0;
        end else if (Line && (r_col != '0)) begin
          // Early line marker: start the next row right away.
          w_sync_hit = 1'b1;
          w_x        = '0;
          w_y        = w_row_inc;
        end
      end
      default: begin
        w_pix_valid = 1'b0;
      end
    endcase
    w_x_next  = (w_x == LAST_COL) ? '0 : w_x + 1'b1;
    w_y_next  = (w_x == LAST_COL) ? ((w_y == LAST_ROW) ? '0 : w_y + 1'b1) : w_y;
    w_buf_idx = w_x[BW-1:0];
  end

  // Raster-position FSM with sticky sync error
  always_ff @(posedge Clk or posedge nReset) begin
    if (nReset) begin
      r_state    <= WAIT_FRAME;
      r_col      <= '0;
      r_row      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_pix_valid) begin
        r_state <= RUN;
        r_col   <= w_x_next;
        r_row   <= w_y_next;
      end
      if (w_sync_hit) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  assign Sync_Err = r_sync_err;

  // One row of history; contents survive reset (rewritten before use)
  logic [7:0] r_line_buf [COLS];

  // Line buffer write: the read of the same slot happens in stage 1 below
  always_ff @(posedge Clk) begin
    if (w_pix_valid) begin
      r_line_buf[w_buf_idx] <= Pixel;
    end
  end

  logic          r_s1_valid;
  logic [7:0]    r_s1_pix;
  logic [7:0]    r_s1_left;
  logic [7:0]    r_s1_up;
  logic [CW-1:0] r_s1_x;
  logic [CW-1:0] r_s1_y;
  logic [7:0]    r_left;

  // Stage 1: capture pixel, its left and up neighbours, and its position
  always_ff @(posedge Clk or posedge nReset) begin
    if (nReset) begin
      r_left     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_left  <= '0;
      r_s1_up    <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_left     <= Pixel;
      r_s1_valid <= w_pix_valid;
      r_s1_pix   <= Pixel;
      r_s1_left  <= r_left;
      r_s1_up    <= r_line_buf[w_buf_idx];
      r_s1_x     <= w_x;
      r_s1_y     <= w_y;
    end
  end

  logic [7:0] w_gx;
  logic [7:0] w_gy;
  logic [8:0] w_mag;
  logic       w_hit;
  logic       w_eof;

  // Gradient magnitude and entry classification
  always_comb begin
    w_gx  = (r_s1_pix >= r_s1_left) ? r_s1_pix - r_s1_left : r_s1_left - r_s1_pix;
    w_gy  = (r_s1_pix >= r_s1_up)   ? r_s1_pix - r_s1_up   : r_s1_up - r_s1_pix;
    w_mag = {1'b0, w_gx} + {1'b0, w_gy};
    w_hit = (r_s1_x != '0) && (r_s1_y != '0) && (w_mag >= 9'(THRESH));
    w_eof = (r_s1_x == LAST_COL) && (r_s1_y == LAST_ROW);
  end

  logic          r_s2_we;
  logic [CW-1:0] r_s2_x;
  logic [CW-1:0] r_s2_y;
  logic          r_s2_hit;
  logic          r_s2_eof;

  // Stage 2: register the candidate FIFO entry
  always_ff @(posedge Clk or posedge nReset) begin
    if (nReset) begin
      r_s2_we  <= 1'b0;
      r_s2_x   <= '0;
      r_s2_y   <= '0;
      r_s2_hit <= 1'b0;
      r_s2_eof <= 1'b0;
    end else begin
      r_s2_we  <= r_s1_valid && (w_hit || w_eof);
      r_s2_x   <= r_s1_x;
      r_s2_y   <= r_s1_y;
      r_s2_hit <= w_hit;
      r_s2_eof <= w_eof;
    end
  end

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_overflow;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [EW-1:0] w_head;

  // FIFO status; a full FIFO still accepts when the head leaves this cycle
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = !w_empty && Edge_Ready;
    w_push  = r_s2_we && (!w_full || w_pop);
    w_head  = r_mem[r_rd_ptr[AW-1:0]];
  end

  // FIFO storage write
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {r_s2_x, r_s2_y, r_s2_hit, r_s2_eof};
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge Clk or posedge nReset) begin
    if (nReset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (r_s2_we && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign Overflow = r_overflow;

  // Show-ahead head presentation; fields read 0 while empty
  always_comb begin
    Edge_Valid = !w_empty;
    Edge_X     = '0;
    Edge_Y     = '0;
    Edge_Hit   = 1'b0;
    Edge_Eof   = 1'b0;
    if (!w_empty) begin
      Edge_X   = w_head[EW-1:CW+2];
      Edge_Y   = w_head[CW+1:2];
      Edge_Hit = w_head[1];
      Edge_Eof = w_head[0];
    end
  end

endmodule
